main_mem_arbiter: RTL and testbench

MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/main_mem_arbiter_rr_select.sv | 41 ++++
 rtl/main_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_main_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Covers the FSM states, the burst owner encoding and the line geometry.
package mem_arb_pkg;

  localparam int WORDS_PER_LINE = 8;
  // Byte-offset bits below the line address: word index plus 2 byte bits.
  localparam int LINE_OFF_W = $clog2(WORDS_PER_LINE) + 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/main_mem_arbiter_rr_select.sv
// Two-requester round-robin pick with a last-granted register.
// On a tie the requester that did not own the previous burst wins.
module rr_select (
  input  logic clk,
  input  logic reset,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic upd_i,
  input  logic upd_owner_i,
  output logic win_o
);
  import mem_arb_pkg::*;

  owner_t last_q, last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= OWN_I;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (upd_i) begin
      last_d = upd_owner_i ? OWN_D : OWN_I;
    end
  end

  // win_o encodes owner_t: 1 selects the data requester.
  always_comb begin
    win_o = 1'b0;
    if (i_req_i && d_req_i) begin
      win_o = (last_q == OWN_I);
    end else begin
      win_o = d_req_i;
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Arbitrates instruction and data L1 line bursts onto one main-memory port.
// A burst is one word per ACCESS, separated by a single-cycle GAP.
//
// state  | meaning
// IDLE   | no owner; arbitrate and latch line/owner/we on any request
// ACCESS | drive mm_re/mm_we for word_idx until mm_valid
// GAP    | one quiet cycle between words
// DONE   | pulse owner's done, record owner as last granted
module main_mem_arbiter #(
  parameter int WORDS_PER_LINE = 8,
  parameter int WORD_SIZE      = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_req,
  input  logic [31:0]                       i_addr,
  output logic                              i_grant,
  output logic                              i_valid,
  output logic                              i_done,
  input  logic                              d_req,
  input  logic                              d_we,
  input  logic [31:0]                       d_addr,
  input  logic [WORD_SIZE-1:0]              d_wdata,
  output logic                              d_grant,
  output logic                              d_valid,
  output logic                              d_done,
  output logic [$clog2(WORDS_PER_LINE)-1:0] word_idx,
  output logic [WORD_SIZE-1:0]              rdata,
  output logic                              mm_re,
  output logic                              mm_we,
  output logic [29:0]                       mm_addr,
  output logic [WORD_SIZE-1:0]              mm_din,
  input  logic [WORD_SIZE-1:0]              mm_dout,
  input  logic                              mm_valid
);
  import mem_arb_pkg::*;

  localparam int IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = (WORDS_PER_LINE == mem_arb_pkg::WORDS_PER_LINE) ?
                          LINE_OFF_W : IDX_W + 2;
  localparam int LINE_W = 32 - OFF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                we_q, we_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                win;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  rr_select u_rr_select (
    .clk         (clk),
    .reset       (reset),
    .i_req_i     (i_req),
    .d_req_i     (d_req),
    .upd_i       (state_q == ST_DONE),
    .upd_owner_i (owner_q == OWN_D),
    .win_o       (win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      line_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    line_d   = line_q;
    idx_d    = idx_q;
    i_grant  = 1'b0;
    d_grant  = 1'b0;
    i_valid  = 1'b0;
    d_valid  = 1'b0;
    i_done   = 1'b0;
    d_done   = 1'b0;
    mm_re    = 1'b0;
    mm_we    = 1'b0;
    mm_addr  = '0;
    mm_din   = '0;
    rdata    = '0;
    word_idx = idx_q;

    if (state_q != ST_IDLE) begin
      i_grant = (owner_q == OWN_I);
      d_grant = (owner_q == OWN_D);
    end

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          owner_d = win ? OWN_D : OWN_I;
          we_d    = win && d_we;
          line_d  = win ? d_addr[31:OFF_W] : i_addr[31:OFF_W];
          idx_d   = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mm_re   = !we_q;
        mm_we   = we_q;
        mm_addr = {line_q, idx_q};
        mm_din  = we_q ? d_wdata : '0;
        if (mm_valid) begin
          i_valid = (owner_q == OWN_I);
          d_valid = (owner_q == OWN_D);
          rdata   = we_q ? '0 : mm_dout;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_ACCESS;
      end
      ST_DONE: begin
        i_done  = (owner_q == OWN_I);
        d_done  = (owner_q == OWN_D);
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs read as zero for the whole reset assertion, not just after the edge.
    if (reset) begin
      i_grant  = 1'b0;
      d_grant  = 1'b0;
      i_valid  = 1'b0;
      d_valid  = 1'b0;
      i_done   = 1'b0;
      d_done   = 1'b0;
      mm_re    = 1'b0;
      mm_we    = 1'b0;
      mm_addr  = '0;
      mm_din   = '0;
      rdata    = '0;
      word_idx = '0;
    end
  end

  a_one_grant: assert property (@(posedge clk) !(i_grant && d_grant));
  a_re_we_excl: assert property (@(posedge clk) !(mm_re && mm_we));

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: the bench acts as both L1 requesters
// and as a main memory with configurable latency.
module tb_main_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_grant, i_valid, i_done;
  logic        d_grant, d_valid, d_done;
  logic [2:0]  word_idx;
  logic [31:0] rdata, mm_din, mm_dout;
  logic        mm_re, mm_we, mm_valid;
  logic [29:0] mm_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Data L1 supplies the writeback word for the current index combinationally.
  assign d_wdata = 32'hA0 + {29'b0, word_idx};

  main_mem_arbiter #(.WORDS_PER_LINE(8), .WORD_SIZE(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_grant  (i_grant),
    .i_valid  (i_valid),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_grant  (d_grant),
    .d_valid  (d_valid),
    .d_done   (d_done),
    .word_idx (word_idx),
    .rdata    (rdata),
    .mm_re    (mm_re),
    .mm_we    (mm_we),
    .mm_addr  (mm_addr),
    .mm_din   (mm_din),
    .mm_dout  (mm_dout),
    .mm_valid (mm_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {24'b0, i_grant, i_valid, i_done, d_grant, d_valid, d_done, mm_re, mm_we}, 32'h0);
    chk({tag, "_idx"}, {29'b0, word_idx}, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_addr"}, {2'b0, mm_addr}, 32'h0);
    chk({tag, "_din"}, mm_din, 32'h0);
  endtask

  // Serves one burst word by word. Called at negedge+1 with the request
  // already raised; returns at negedge+1 of the IDLE cycle after DONE, or
  // at the first ACCESS cycle of word stop_w.
  task automatic burst(input bit own_d, input bit wr, input logic [29:0] base,
                       input int lat, input int drop_w, input bit gap_valid,
                       input bit release_req, input int stop_w);
    logic [31:0] sv_i, sv_d, dat;
    logic        sv_we;
    int          n;
    sv_i  = i_addr;
    sv_d  = d_addr;
    sv_we = d_we;
    for (int w = 0; w < 8; w++) begin
      n = 0;
      do begin
        @(negedge clk);
        mm_valid = 1'b0;
        #1;
        n++;
      end while (!(mm_re || mm_we) && n < 12);
      chk("access_wait", n, 1);
      if (w == stop_w) begin
        i_addr = sv_i;
        d_addr = sv_d;
        d_we   = sv_we;
        return;
      end
      chk("mm_addr", {2'b0, mm_addr}, {2'b0, base + 30'(w)});
      chk("mm_re", mm_re, !wr);
      chk("mm_we", mm_we, wr);
      chk("word_idx", {29'b0, word_idx}, w);
      chk("own_grant", own_d ? d_grant : i_grant, 1);
      chk("other_grant", own_d ? i_grant : d_grant, 0);
      if (wr) chk("mm_din", mm_din, 32'hA0 + w);
      for (int k = 1; k < lat; k++) begin
        @(negedge clk);
        #1;
        chk("hold_addr", {2'b0, mm_addr}, {2'b0, base + 30'(w)});
        chk("early_valid", {i_valid, d_valid}, 0);
      end
      dat      = 32'h5A00_0000 ^ {2'b0, base + 30'(w)};
      mm_dout  = dat;
      mm_valid = 1'b1;
      #1;
      chk("own_valid", own_d ? d_valid : i_valid, 1);
      chk("other_valid", own_d ? i_valid : d_valid, 0);
      chk("rdata", rdata, wr ? 32'h0 : dat);
      if (w == 1) begin
        i_addr ^= 32'hFFFF_0000;
        d_addr ^= 32'h00FF_0000;
        d_we    = !d_we;
      end
      if (w == drop_w) begin
        if (own_d) d_req = 1'b0;
        else       i_req = 1'b0;
      end
      @(negedge clk);
      if (w == 7 || !gap_valid) mm_valid = 1'b0;
      #1;
      if (w < 7) begin
        chk("gap_quiet", {mm_re, mm_we, i_valid, d_valid, i_done, d_done}, 0);
        chk("gap_idx", {29'b0, word_idx}, w + 1);
      end else begin
        chk("own_done", own_d ? d_done : i_done, 1);
        chk("other_done", own_d ? i_done : d_done, 0);
        chk("done_quiet", {mm_re, mm_we}, 0);
        i_addr = sv_i;
        d_addr = sv_d;
        d_we   = sv_we;
        if (release_req) begin
          if (own_d) d_req = 1'b0;
          else       i_req = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("idle_gap", {i_grant, d_grant, i_done, d_done, mm_re, mm_we}, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    i_req    = 1'b1;
    d_req    = 1'b1;
    d_we     = 1'b1;
    i_addr   = 32'h0000_1234;
    d_addr   = 32'h0000_6040;
    mm_dout  = 32'hFFFF_FFFF;
    mm_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset    = 1'b0;
    i_req    = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    mm_valid = 1'b0;
    #1;

    // Tie after reset: data first, then a held tie goes to instruction.
    i_req = 1'b1;
    d_req = 1'b1;
    burst(1'b1, 1'b0, 30'h1810, 1, 99, 1'b0, 1'b0, 8);
    burst(1'b0, 1'b0, 30'h0488, 1, 99, 1'b0, 1'b1, 8);
    burst(1'b1, 1'b0, 30'h1810, 1, 99, 1'b0, 1'b1, 8);

    // mm_valid while idle is ignored.
    mm_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("idle_mmvalid", {i_valid, d_valid, i_grant, d_grant, word_idx}, 0);
    end
    mm_valid = 1'b0;

    // Instruction fill, 3-cycle memory.
    i_addr = 32'h0000_1234;
    i_req  = 1'b1;
    burst(1'b0, 1'b0, 30'h0488, 3, 99, 1'b0, 1'b1, 8);

    // Data writeback, 2-cycle memory, mm_valid left high through each GAP.
    d_addr = 32'h0000_6040;
    d_we   = 1'b1;
    d_req  = 1'b1;
    burst(1'b1, 1'b1, 30'h1810, 2, 99, 1'b1, 1'b1, 8);

    // Data fill with d_req dropped after word 2.
    d_we  = 1'b0;
    d_req = 1'b1;
    burst(1'b1, 1'b0, 30'h1810, 1, 2, 1'b0, 1'b1, 8);

    // Reset at word 3, then a fresh burst restarts at word 0.
    i_req = 1'b1;
    burst(1'b0, 1'b0, 30'h0488, 1, 99, 1'b0, 1'b0, 3);
    reset = 1'b1;
    i_req = 1'b0;
    #1;
    chk_all_zero("rst_now");
    @(negedge clk);
    #1;
    chk_all_zero("rst_next");
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("post_rst_quiet", {i_done, d_done, i_grant, d_grant, mm_re, mm_we}, 0);
    end
    i_req = 1'b1;
    burst(1'b0, 1'b0, 30'h0488, 1, 99, 1'b1, 1'b1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
